// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU execute/writeback stage.
// Holds the opcode encodings seen by the stage, the state encoding, status flag
// bit positions, destination select values and small opcode decode helpers.
package alu_writeback_pkg;

  // Opcode encodings; 4'h9..4'hF are undefined.
  localparam logic [3:0] OpAddwp = 4'h0;
  localparam logic [3:0] OpSubwp = 4'h1;
  localparam logic [3:0] OpAndwp = 4'h2;
  localparam logic [3:0] OpIorwp = 4'h3;
  localparam logic [3:0] OpXorwp = 4'h4;
  localparam logic [3:0] OpCmpwp = 4'h5;
  localparam logic [3:0] OpMovwp = 4'h6;
  localparam logic [3:0] OpIncwp = 4'h7;
  localparam logic [3:0] OpDecwp = 4'h8;

  typedef enum logic {
    StIdle    = 1'b0,
    StMemWait = 1'b1
  } wb_state_e;

  // Status register bit positions.
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;

  localparam logic DestW   = 1'b0;
  localparam logic DestMem = 1'b1;

  // Only the arithmetic ops produce a meaningful carry.
  function automatic logic op_writes_c(logic [3:0] op);
    return (op == OpAddwp) || (op == OpSubwp);
  endfunction

  // Defined, non-compare ops commit a result; compare and undefined ops touch flags only.
  function automatic logic op_commits(logic [3:0] op);
    return (op <= OpDecwp) && (op != OpCmpwp);
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Memory-ack timeout counter for the writeback stage.
// Ports: clk/rst_n (async active-low), clear restarts the count, enable counts
// one cycle, expired pulses on the enabled cycle whose edge brings the count to
// ACK_TIMEOUT. ACK_TIMEOUT=0 never expires and the counter saturates.
module wb_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntLast = (ACK_TIMEOUT == 0) ? '0 : CntW'(ACK_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the edge where the count would reach ACK_TIMEOUT.
  assign expired = (ACK_TIMEOUT != 0) && enable && !clear && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Execute/writeback stage behind the ALU.
// Accepts a result (i_valid/o_ready), updates the Z/N/C status register, and
// commits the result either to W (o_w, fed back to the ALU) or to data memory
// through a held write request (o_mem_we/addr/data) that ends on i_mem_ack or
// after ACK_TIMEOUT cycles, the latter raising the sticky o_err (cleared by
// i_err_clr; a new error wins over a clear in the same cycle).
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [DATA_W-1:0] i_res,
  input  logic [2:0]        i_status,
  input  logic              i_dest,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_w,
  output logic [2:0]        o_status,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_ack,
  output logic              o_err,
  input  logic              i_err_clr
);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [2:0]        status_q, status_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              err_q, err_d;
  logic              accept, err_set, timer_clear, timer_en, timer_expired;

  assign o_ready  = (state_q == StIdle);
  assign accept   = i_valid && o_ready;
  assign timer_en = (state_q == StMemWait);

  wb_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    status_d    = status_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    err_set     = 1'b0;
    timer_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          status_d[FlagZ] = i_status[FlagZ];
          status_d[FlagN] = i_status[FlagN];
          if (op_writes_c(i_opcode)) begin
            status_d[FlagC] = i_status[FlagC];
          end
          if (op_commits(i_opcode)) begin
            if (i_dest == DestMem) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = i_addr;
              mem_data_d  = i_res;
              timer_clear = 1'b1;
              state_d     = StMemWait;
            end else begin
              w_d = i_res;
            end
          end
        end
      end
      StMemWait: begin
        // Ack takes priority over a timeout on the same edge.
        if (i_mem_ack) begin
          mem_we_d = 1'b0;
          state_d  = StIdle;
        end else if (timer_expired) begin
          mem_we_d = 1'b0;
          err_set  = 1'b1;
          state_d  = StIdle;
        end
      end
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      w_q        <= '0;
      status_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      status_q   <= status_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  assign o_w        = w_q;
  assign o_status   = status_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback (ACK_TIMEOUT=4). Stimulus pushes
// hand-computed expectations; a monitor pops them when an accept's result
// becomes visible or when a memory write request ends.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_opcode = '0;
  logic [7:0] i_res = '0;
  logic [2:0] i_status = '0;
  logic       i_dest = 1'b0;
  logic [4:0] i_addr = '0;
  logic [7:0] o_w;
  logic [2:0] o_status;
  logic       o_mem_we;
  logic [4:0] o_mem_addr;
  logic [7:0] o_mem_data;
  logic       i_mem_ack = 1'b0;
  logic       o_err;
  logic       i_err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] w;
    logic [2:0] st;
    string      name;
  } acc_exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    int         cycles;
    logic       err;
    string      name;
  } mem_exp_t;

  acc_exp_t acc_q[$];
  mem_exp_t mem_q[$];

  always #5 clk = ~clk;

  alu_writeback #(
    .DATA_W     (8),
    .ADDR_W     (5),
    .ACK_TIMEOUT(4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_opcode  (i_opcode),
    .i_res     (i_res),
    .i_status  (i_status),
    .i_dest    (i_dest),
    .i_addr    (i_addr),
    .o_w       (o_w),
    .o_status  (o_status),
    .o_mem_we  (o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data),
    .i_mem_ack (i_mem_ack),
    .o_err     (o_err),
    .i_err_clr (i_err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic       prev_acc, prev_we, in_prog, stable;
    logic [4:0] a0;
    logic [7:0] d0;
    int         cyc;
    acc_exp_t   ea;
    mem_exp_t   em;
    prev_acc = 1'b0;
    prev_we  = 1'b0;
    in_prog  = 1'b0;
    stable   = 1'b1;
    a0       = '0;
    d0       = '0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_acc = 1'b0;
        prev_we  = 1'b0;
        in_prog  = 1'b0;
        continue;
      end
      if (prev_acc) begin
        if (acc_q.size() == 0) begin
          check("acc_unexpected", acc_q.size(), 1);
        end else begin
          ea = acc_q.pop_front();
          check({ea.name, "_w"}, o_w, ea.w);
          check({ea.name, "_status"}, o_status, ea.st);
        end
      end
      if (o_mem_we) begin
        if (!in_prog) begin
          in_prog = 1'b1;
          a0      = o_mem_addr;
          d0      = o_mem_data;
          cyc     = 1;
          stable  = !o_ready;
        end else begin
          cyc++;
          if (o_mem_addr !== a0 || o_mem_data !== d0 || o_ready !== 1'b0) stable = 1'b0;
        end
      end else if (prev_we && in_prog) begin
        in_prog = 1'b0;
        if (mem_q.size() == 0) begin
          check("mem_unexpected", mem_q.size(), 1);
        end else begin
          em = mem_q.pop_front();
          check({em.name, "_addr"}, a0, em.addr);
          check({em.name, "_data"}, d0, em.data);
          check({em.name, "_we_cycles"}, cyc, em.cycles);
          check({em.name, "_stable"}, stable, 1);
          check({em.name, "_ready_after"}, o_ready, 1);
          check({em.name, "_err"}, o_err, em.err);
        end
      end
      prev_acc = i_valid && o_ready;
      prev_we  = o_mem_we;
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 32) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (o_ready !== 1'b1) check({name, "_ready_timeout"}, o_ready, 1);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [7:0] res,
                       input logic [2:0] st, input logic dest, input logic [4:0] addr,
                       input logic [7:0] exp_w, input logic [2:0] exp_st);
    acc_exp_t e;
    wait_ready(name);
    e.w  = exp_w;
    e.st = exp_st;
    e.name = name;
    acc_q.push_back(e);
    i_opcode = op;
    i_res    = res;
    i_status = st;
    i_dest   = dest;
    i_addr   = addr;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic mem_write(input string name, input logic [3:0] op, input logic [7:0] res,
                           input logic [2:0] st, input logic [4:0] addr,
                           input logic [7:0] exp_w, input logic [2:0] exp_st,
                           input int ack_delay, input int exp_cycles, input logic exp_err,
                           input logic track);
    mem_exp_t m;
    if (track) begin
      m.addr = addr;
      m.data = res;
      m.cycles = exp_cycles;
      m.err = exp_err;
      m.name = name;
      mem_q.push_back(m);
    end
    issue(name, op, res, st, 1'b1, addr, exp_w, exp_st);
    if (ack_delay > 0) begin
      repeat (ack_delay - 1) begin
        @(posedge clk);
        #1;
      end
      i_mem_ack = 1'b1;
      @(posedge clk);
      #1;
      i_mem_ack = 1'b0;
    end
    if (track) wait_ready(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_w", o_w, 8'h00);
    check("rst_status", o_status, 3'b000);
    check("rst_we", o_mem_we, 1'b0);
    check("rst_addr", o_mem_addr, 5'h00);
    check("rst_data", o_mem_data, 8'h00);
    check("rst_err", o_err, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Flag and W behaviour.
    issue("add_w", OpAddwp, 8'h00, 3'b101, DestW, 5'h00, 8'h00, 3'b101);
    check("add_w_ready", o_ready, 1'b1);
    issue("and_c_hold", OpAndwp, 8'h80, 3'b010, DestW, 5'h00, 8'h80, 3'b110);
    issue("cmp_flags", OpCmpwp, 8'hFF, 3'b010, DestW, 5'h00, 8'h80, 3'b110);
    issue("cmp_dest_mem", OpCmpwp, 8'h3C, 3'b001, DestMem, 5'h1F, 8'h80, 3'b101);
    issue("undef_op", 4'hF, 8'h80, 3'b010, DestW, 5'h00, 8'h80, 3'b110);
    issue("sub_c_clr", OpSubwp, 8'h7F, 3'b010, DestW, 5'h00, 8'h7F, 3'b010);
    issue("add_c_set", OpAddwp, 8'h01, 3'b100, DestW, 5'h00, 8'h01, 3'b100);

    // Memory write acked after 3 cycles.
    mem_write("sub_mem_ack3", OpSubwp, 8'h3C, 3'b100, 5'h1F, 8'h01, 3'b100, 3, 3, 1'b0, 1'b1);

    // Timeout without ack; error is sticky until cleared.
    mem_write("add_mem_tmo", OpAddwp, 8'hA5, 3'b001, 5'h05, 8'h01, 3'b001, 0, 4, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", o_err, 1'b1);
    i_err_clr = 1'b1;
    @(posedge clk);
    #1;
    i_err_clr = 1'b0;
    check("err_cleared", o_err, 1'b0);

    // Ack on the timeout edge: no error.
    mem_write("xor_ack_on_tmo", OpXorwp, 8'h5A, 3'b010, 5'h0A, 8'h01, 3'b010, 4, 4, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("err_after_ack_tmo", o_err, 1'b0);

    // Clear held through a new timeout: set wins.
    i_err_clr = 1'b1;
    mem_write("ior_tmo_clr", OpIorwp, 8'hC3, 3'b110, 5'h12, 8'h01, 3'b010, 0, 4, 1'b1, 1'b1);
    i_err_clr = 1'b0;
    @(posedge clk);
    #1;
    check("err_set_wins_hold", o_err, 1'b1);
    i_err_clr = 1'b1;
    @(posedge clk);
    #1;
    i_err_clr = 1'b0;
    check("err_cleared2", o_err, 1'b0);

    // Asynchronous reset in the middle of a memory write.
    issue("add_w99", OpAddwp, 8'h99, 3'b000, DestW, 5'h00, 8'h99, 3'b000);
    mem_write("mov_mem_rst", OpMovwp, 8'h11, 3'b011, 5'h03, 8'h99, 3'b011, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_we", o_mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", o_mem_we, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_w", o_w, 8'h00);
    check("mid_rst_status", o_status, 3'b000);
    check("mid_rst_addr", o_mem_addr, 5'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue("post_rst_add", OpAddwp, 8'h55, 3'b100, DestW, 5'h00, 8'h55, 3'b100);
    mem_write("post_rst_mem1", OpAndwp, 8'hE1, 3'b010, 5'h07, 8'h55, 3'b110, 1, 1, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("acc_q_drained", acc_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
